glb_ctrl: RTL
=============

# glb_ctrl

Sequencer for the global buffer bank of PE_SIZE row FIFOs that feeds the systolic GEMM array. One tile runs per start command. The controller accepts a tile of row vectors over a valid/ready stream and writes them into all FIFOs in parallel. It then issues the read burst that the buffer skews row by row, produces per-row data-valid strobes aligned to the skewed read data, and signals completion once the last row has drained.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per FIFO entry
- FIFO_DEPTH, 16, entries per row FIFO; also the maximum tile length
- PE_SIZE, 16, number of row FIFOs and array rows
- LW, $clog2(FIFO_DEPTH+1), width of the tile-length field

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  tile start request, sampled only in IDLE
- len_i  in  LW  tile length in rows, sampled with start_i; legal range 1..FIFO_DEPTH
- in_valid_i  in  1  input row vector valid
- in_ready_o  out  1  controller can accept a row vector
- in_data_i  in  DATA_WIDTH*PE_SIZE  row vector, passed through to the buffer write data
- glb_wren_o  out  1  buffer write enable
- glb_wdata_o  out  DATA_WIDTH*PE_SIZE  buffer write data
- glb_rden_o  out  1  buffer read enable, drives row 0; the buffer delays it internally for later rows
- glb_full_i  in  PE_SIZE  buffer full flags
- glb_empty_i  in  PE_SIZE  buffer empty flags
- col_valid_o  out  PE_SIZE  bit j high when row j read data is valid at the array edge
- busy_o  out  1  controller is not in IDLE
- done_o  out  1  one-cycle tile-complete pulse
- err_o  out  1  one-cycle error pulse

## Operation
- FSM states: IDLE, LOAD, STREAM, SKEW, DONE.
- IDLE:
  - start_i with 1 ≤ len_i ≤ FIFO_DEPTH: latch len_i, clear the counters, go to LOAD.
  - start_i with len_i = 0 or len_i > FIFO_DEPTH: pulse err_o, stay in IDLE.
- LOAD:
  - in_ready_o = !glb_full_i[0].
  - glb_wren_o = in_valid_i && in_ready_o, combinational; glb_wdata_o = in_data_i.
  - Each write increments wr_cnt. The write with wr_cnt = len−1 moves the FSM to STREAM.
- STREAM:
  - glb_rden_o = 1 for exactly len cycles, counted by rd_cnt.
  - After the len-th cycle, go to SKEW.
- SKEW: wait exactly PE_SIZE cycles, covering the PE_SIZE−1 row skew plus the 1-cycle FIFO read latency. Then go to DONE.
- DONE:
  - done_o = 1 for one cycle, then IDLE.
  - If glb_empty_i is not all ones in this cycle, err_o also pulses (leftover data).
- col_valid_o: shift register fed by glb_rden_o. col_valid_o[j] = glb_rden_o delayed by j+1 cycles. It keeps shifting in every state.
- start_i outside IDLE is ignored (no error).
- in_ready_o = 0 and glb_wren_o = 0 outside LOAD; glb_rden_o = 0 outside STREAM.
- busy_o = (state != IDLE).
- Counters are LW bits wide and never wrap, because len ≤ FIFO_DEPTH.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: in_ready_o, glb_wren_o, glb_rden_o, col_valid_o, busy_o, done_o and err_o are all 0.
  - Counters and latched len: 0.
- Reset in any state returns to IDLE on the next edge and clears col_valid_o.
  - Buffer contents are not cleared by this block. The integrator drives the buffer reset from the same source.
- start_i sampled at cycle 0 → LOAD at cycle 1; in_ready_o can be high from cycle 1.
- Last write at cycle t → glb_rden_o high for cycles t+1 … t+len → SKEW for t+len+1 … t+len+PE_SIZE → done_o at t+len+PE_SIZE+1.
- Last col_valid_o[PE_SIZE−1] pulse is at cycle t+len+PE_SIZE, one cycle before done_o.
- Back-to-back tiles: the next start_i is accepted in the cycle after done_o, i.e. the first IDLE cycle.
- If glb_full_i[0] is high, the stall holds with no write and no count; this cannot occur for legal lengths.

## Test plan
- Basic tile:
  - Stimulus: PE_SIZE=4, FIFO_DEPTH=16, len=4, in_valid_i held high, rows 0x01020304 … 0x0D0E0F10.
  - Required: 4 writes in cycles 1–4; glb_rden_o high in cycles 5–8; col_valid_o[3] high in cycles 9–12; done_o at cycle 13; err_o stays 0.
- Input gaps:
  - Stimulus: len=3, in_valid_i toggling every other cycle.
  - Required: exactly 3 writes; STREAM starts the cycle after the 3rd write; done_o at last write + 3 + 4 + 1.
- Maximum tile:
  - Stimulus: len=16.
  - Required: 16 writes; glb_full_i[0] high after the 16th write; no 17th write; 16 rden cycles; done_o; err_o = 0.
- Illegal length:
  - Stimulus: start with len=0, then start with len=17.
  - Required: err_o pulses once each; busy_o stays 0; no wren and no rden.
- Reset mid-tile:
  - Stimulus: assert rst in the 2nd STREAM cycle.
  - Required: next cycle state is IDLE, glb_rden_o = 0, col_valid_o = 0, busy_o = 0; a new start is accepted afterwards.
- Start while busy, plus leftover check:
  - Stimulus: pulse start_i during SKEW; separately, force glb_empty_i[2]=0 during DONE.
  - Required: the extra start is ignored and no second tile runs; err_o pulses coincident with done_o.

Source files
------------

// File: rtl/glb_ctrl.sv
// Tile sequencer for the global buffer bank: loads a tile of row vectors into all row FIFOs,
// issues the read burst, tracks the row skew with per-row valid strobes and reports completion.
module glb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PE_SIZE    = 16,
  parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [LW-1:0]                 len_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] in_data_i,
  output logic                          glb_wren_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
  output logic                          glb_rden_o,
  input  logic [PE_SIZE-1:0]            glb_full_i,
  input  logic [PE_SIZE-1:0]            glb_empty_i,
  output logic [PE_SIZE-1:0]            col_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int SW = $clog2(PE_SIZE + 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] ONE_L     = LW'(1);
  localparam logic [SW-1:0] SKEW_LAST = SW'(PE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    SKEW   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [LW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [SW-1:0]       sk_cnt_q, sk_cnt_d;
  logic [PE_SIZE-1:0]  cv_q, cv_d;

  // All rows are written in lockstep, so row 0 stands for the whole bank.
  logic unused_full;
  assign unused_full = ^glb_full_i[PE_SIZE-1:1];

  // Next-state, counters and handshake outputs
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    sk_cnt_d   = sk_cnt_q;
    in_ready_o = 1'b0;
    glb_wren_o = 1'b0;
    glb_rden_o = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((len_i != '0) && (len_i <= DEPTH_L)) begin
            len_d    = len_i;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            sk_cnt_d = '0;
            state_d  = LOAD;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready_o = !glb_full_i[0];
        glb_wren_o = in_valid_i && !glb_full_i[0];
        if (glb_wren_o) begin
          wr_cnt_d = wr_cnt_q + ONE_L;
          if (wr_cnt_q == len_q - ONE_L) begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        glb_rden_o = 1'b1;
        rd_cnt_d   = rd_cnt_q + ONE_L;
        if (rd_cnt_q == len_q - ONE_L) begin
          sk_cnt_d = '0;
          state_d  = SKEW;
        end
      end
      SKEW: begin
        sk_cnt_d = sk_cnt_q + SW'(1);
        if (sk_cnt_q == SKEW_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        err_o   = !(&glb_empty_i);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Strobe for row j trails the row-0 read enable by j+1 cycles (skew plus read latency).
    cv_d = {cv_q[PE_SIZE-2:0], glb_rden_o};
  end

  assign glb_wdata_o = in_data_i;
  assign busy_o      = (state_q != IDLE);
  assign col_valid_o = cv_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      sk_cnt_q <= '0;
      cv_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      sk_cnt_q <= sk_cnt_d;
      cv_q     <= cv_d;
    end
  end

endmodule
